// File: rtl/warp_pkg.sv
// warp_pkg: types and constants shared by the warp execution units.
// Holds the ALU opcode set, lane width and saturation limits.
package warp_pkg;

   localparam int DATA_WIDTH = 32;
   localparam int NUM_LANES  = 4;

   typedef enum logic [2:0] {
      ADD  = 3'd0,
      MUL  = 3'd1,
      FMA  = 3'd2,
      MAX  = 3'd3,
      RELU = 3'd4
   } alu_opcode_e;

   localparam logic [DATA_WIDTH-1:0] sat_max =
      {1'b0, {(DATA_WIDTH-1){1'b1}}};
   localparam logic [DATA_WIDTH-1:0] sat_min =
      {1'b1, {(DATA_WIDTH-1){1'b0}}};

endpackage

// File: rtl/simd_alu_lane.sv
// simd_alu_lane: one lane of second-stage ALU logic.
// Exact result, overflow detect, wrap/clamp and lane masking.
module simd_alu_lane
   import warp_pkg::*;
#(
   parameter int W = DATA_WIDTH
) (
   input  alu_opcode_e           i_op,
   input  logic                  i_sat,
   input  logic                  i_en,
   input  logic signed [W-1:0]   i_a,
   input  logic signed [W-1:0]   i_b,
   input  logic signed [W-1:0]   i_c,
   input  logic signed [2*W-1:0] i_prod,
   output logic [W-1:0]          o_res,
   output logic                  o_ovf
);

   localparam int EW = 2*W + 2;
   localparam logic signed [EW-1:0] LMAX =
      EW'({1'b0, {(W-1){1'b1}}});
   localparam logic signed [EW-1:0] LMIN =
      EW'($signed({1'b1, {(W-1){1'b0}}}));

   logic signed [EW-1:0] w_exact;
   logic                 w_arith;
   logic                 w_def;
   logic                 w_ovf;

   // Exact full-precision result of the selected operation
   always_comb begin
      w_exact = '0;
      w_arith = 1'b0;
      w_def   = 1'b1;
      case (i_op)
         ADD: begin
            w_exact = EW'(i_a) + EW'(i_b);
            w_arith = 1'b1;
         end
         MUL: begin
            w_exact = EW'(i_prod);
            w_arith = 1'b1;
         end
         FMA: begin
            w_exact = EW'(i_prod) + EW'(i_c);
            w_arith = 1'b1;
         end
         MAX:  w_exact = (i_a > i_b) ? EW'(i_a) : EW'(i_b);
         RELU: w_exact = i_a[W-1] ? '0 : EW'(i_a);
         default: w_def = 1'b0;
      endcase
   end

   assign w_ovf = w_arith &&
      ((w_exact > LMAX) || (w_exact < LMIN));

   // Mask, then wrap or clamp into the lane width
   always_comb begin
      o_res = '0;
      o_ovf = 1'b0;
      if (i_en && w_def) begin
         o_ovf = w_ovf;
         if (w_ovf && i_sat)
            o_res = w_exact[EW-1] ? LMIN[W-1:0] : LMAX[W-1:0];
         else
            o_res = w_exact[W-1:0];
      end
   end

endmodule

// File: rtl/simd_alu_pipe.sv
// simd_alu_pipe: two-stage multi-lane integer ALU with valid/ready.
// Stage 1 captures operands and products, stage 2 finishes and registers.
module simd_alu_pipe
   import warp_pkg::alu_opcode_e;
#(
   parameter int DATA_WIDTH = warp_pkg::DATA_WIDTH,
   parameter int NUM_LANES  = warp_pkg::NUM_LANES
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            in_valid,
   output logic                            in_ready,
   input  alu_opcode_e                     in_opcode,
   input  logic                            in_sat,
   input  logic [NUM_LANES-1:0]            in_mask,
   input  logic [NUM_LANES*DATA_WIDTH-1:0] in_op1,
   input  logic [NUM_LANES*DATA_WIDTH-1:0] in_op2,
   input  logic [NUM_LANES*DATA_WIDTH-1:0] in_op3,
   output logic                            out_valid,
   input  logic                            out_ready,
   output logic [NUM_LANES*DATA_WIDTH-1:0] out_result,
   output logic [NUM_LANES-1:0]            out_ovf,
   output logic                            ovf_sticky,
   input  logic                            ovf_clr
);

   localparam int W = DATA_WIDTH;
   localparam int L = NUM_LANES;

   logic             r_s1_valid;
   logic             r_s2_valid;
   alu_opcode_e      r_s1_op;
   logic             r_s1_sat;
   logic [L-1:0]     r_s1_mask;
   logic [L*W-1:0]   r_s1_op1;
   logic [L*W-1:0]   r_s1_op2;
   logic [L*W-1:0]   r_s1_op3;
   logic [L*2*W-1:0] r_s1_prod;
   logic [L*W-1:0]   r_out_result;
   logic [L-1:0]     r_out_ovf;
   logic             r_sticky;

   logic [L*2*W-1:0] w_prod;
   logic [L*W-1:0]   w_res;
   logic [L-1:0]     w_ovf;
   logic             w_s1_adv;
   logic             w_s2_adv;

   assign w_s2_adv   = !r_s2_valid || out_ready;
   assign w_s1_adv   = !r_s1_valid || w_s2_adv;
   assign in_ready   = w_s1_adv;
   assign out_valid  = r_s2_valid;
   assign out_result = r_out_result;
   assign out_ovf    = r_out_ovf;
   assign ovf_sticky = r_sticky;

   for (genvar gi = 0; gi < L; gi++) begin : g_lane
      logic signed [2*W-1:0] w_a;
      logic signed [2*W-1:0] w_b;

      assign w_a = (2*W)'($signed(in_op1[gi*W +: W]));
      assign w_b = (2*W)'($signed(in_op2[gi*W +: W]));
      assign w_prod[gi*2*W +: 2*W] = w_a * w_b;

      simd_alu_lane #(.W(W)) u_lane (
         .i_op   (r_s1_op),
         .i_sat  (r_s1_sat),
         .i_en   (r_s1_mask[gi]),
         .i_a    (r_s1_op1[gi*W +: W]),
         .i_b    (r_s1_op2[gi*W +: W]),
         .i_c    (r_s1_op3[gi*W +: W]),
         .i_prod (r_s1_prod[gi*2*W +: 2*W]),
         .o_res  (w_res[gi*W +: W]),
         .o_ovf  (w_ovf[gi])
      );
   end

   // Stage 1: capture the beat and its exact products
   always_ff @(posedge clk) begin
      if (rst) begin
         r_s1_valid <= 1'b0;
      end else if (w_s1_adv) begin
         r_s1_valid <= in_valid;
         if (in_valid) begin
            r_s1_op   <= in_opcode;
            r_s1_sat  <= in_sat;
            r_s1_mask <= in_mask;
            r_s1_op1  <= in_op1;
            r_s1_op2  <= in_op2;
            r_s1_op3  <= in_op3;
            r_s1_prod <= w_prod;
         end
      end
   end

   // Stage 2: register lane results, hold them while stalled
   always_ff @(posedge clk) begin
      if (rst) begin
         r_s2_valid   <= 1'b0;
         r_out_result <= '0;
         r_out_ovf    <= '0;
      end else if (w_s2_adv) begin
         r_s2_valid <= r_s1_valid;
         if (r_s1_valid) begin
            r_out_result <= w_res;
            r_out_ovf    <= w_ovf;
         end
      end
   end

   // Sticky overflow: set on an overflowing handoff, set beats clear
   always_ff @(posedge clk) begin
      if (rst)
         r_sticky <= 1'b0;
      else if (r_s2_valid && out_ready && |r_out_ovf)
         r_sticky <= 1'b1;
      else if (ovf_clr)
         r_sticky <= 1'b0;
   end

endmodule

// File: tb/tb_simd_alu_pipe.sv
// tb_simd_alu_pipe: scoreboard bench for the pipelined SIMD ALU.
// Driver queues expected beats, a monitor pops them on each handoff.
module tb_simd_alu_pipe;
   import warp_pkg::*;

   localparam int W = 32;
   localparam int L = 4;

   typedef logic [L*W-1:0] vec_t;
   typedef struct {
      vec_t         res;
      logic [L-1:0] ovf;
      int           acc;
   } exp_t;

   logic         clk = 1'b0;
   logic         rst;
   logic         in_valid;
   logic         in_ready;
   alu_opcode_e  in_opcode;
   logic         in_sat;
   logic [L-1:0] in_mask;
   vec_t         in_op1;
   vec_t         in_op2;
   vec_t         in_op3;
   logic         out_valid;
   logic         out_ready;
   vec_t         out_result;
   logic [L-1:0] out_ovf;
   logic         ovf_sticky;
   logic         ovf_clr;

   exp_t q[$];
   int   n_cmp = 0;
   int   n_err = 0;
   int   cyc = 0;
   int   last_acc = 0;
   int   first_acc = 0;
   bit   lat_chk = 1'b0;

   simd_alu_pipe #(.DATA_WIDTH(W), .NUM_LANES(L)) dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_opcode  (in_opcode),
      .in_sat     (in_sat),
      .in_mask    (in_mask),
      .in_op1     (in_op1),
      .in_op2     (in_op2),
      .in_op3     (in_op3),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_result (out_result),
      .out_ovf    (out_ovf),
      .ovf_sticky (ovf_sticky),
      .ovf_clr    (ovf_clr)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   function automatic vec_t v4(input logic [31:0] l0, l1, l2, l3);
      return {l3, l2, l1, l0};
   endfunction

   task automatic chk(input string nm, input vec_t act, input vec_t exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic send(input alu_opcode_e op, input logic sat,
                       input logic [L-1:0] m, input vec_t a, b, c,
                       input vec_t r, input logic [L-1:0] o);
      bit   acc = 1'b0;
      int   t = 0;
      exp_t e;
      @(negedge clk);
      in_valid  = 1'b1;
      in_opcode = op;
      in_sat    = sat;
      in_mask   = m;
      in_op1    = a;
      in_op2    = b;
      in_op3    = c;
      while (!acc && t < 50) begin
         #2;
         acc   = in_ready;
         e.acc = cyc;
         @(posedge clk);
         if (!acc) begin
            @(negedge clk);
            t++;
         end
      end
      if (acc) begin
         e.res = r;
         e.ovf = o;
         q.push_back(e);
         last_acc = e.acc;
      end else begin
         chk("send_timeout", vec_t'(0), vec_t'(1));
      end
   endtask

   task automatic idle();
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic wait_drain();
      int t = 0;
      while (q.size() != 0 && t < 60) begin
         @(posedge clk);
         t++;
      end
      chk("drain", vec_t'(q.size()), vec_t'(0));
      @(posedge clk);
   endtask

   // Monitor: compare each handoff against the scoreboard
   initial begin
      bit           pv = 1'b0;
      bit           pr = 1'b0;
      vec_t         pres = '0;
      logic [L-1:0] povf = '0;
      exp_t         e;
      forever begin
         @(negedge clk);
         #4;
         if (rst) begin
            pv = 1'b0;
         end else begin
            if (pv && !pr) begin
               chk("hold_valid", vec_t'(out_valid), vec_t'(1));
               chk("hold_result", out_result, pres);
               chk("hold_ovf", vec_t'(out_ovf), vec_t'(povf));
            end
            if (q.size() == 2 && !out_ready)
               chk("in_ready_full", vec_t'(in_ready), vec_t'(0));
            if (out_valid && out_ready) begin
               if (q.size() == 0) begin
                  chk("unexpected_beat", vec_t'(1), vec_t'(0));
               end else begin
                  e = q.pop_front();
                  chk("result", out_result, e.res);
                  chk("ovf", vec_t'(out_ovf), vec_t'(e.ovf));
                  if (lat_chk)
                     chk("latency", vec_t'(cyc - e.acc), vec_t'(2));
               end
            end
            pv   = out_valid;
            pr   = out_ready;
            pres = out_result;
            povf = out_ovf;
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   // Directed stimulus
   initial begin
      rst       = 1'b1;
      in_valid  = 1'b0;
      in_opcode = ADD;
      in_sat    = 1'b0;
      in_mask   = '0;
      in_op1    = '0;
      in_op2    = '0;
      in_op3    = '0;
      out_ready = 1'b1;
      ovf_clr   = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      #4;
      chk("rst_out_valid", vec_t'(out_valid), vec_t'(0));
      chk("rst_out_result", out_result, vec_t'(0));
      chk("rst_out_ovf", vec_t'(out_ovf), vec_t'(0));
      chk("rst_sticky", vec_t'(ovf_sticky), vec_t'(0));
      chk("rst_in_ready", vec_t'(in_ready), vec_t'(1));

      // ADD wrap
      send(ADD, 1'b0, 4'hF,
           v4(32'h7FFFFFFF, 32'd5, 32'hFFFFFFFF, 32'h80000000),
           v4(32'd1, 32'd7, 32'hFFFFFFFF, 32'hFFFFFFFF), '0,
           v4(32'h80000000, 32'd12, 32'hFFFFFFFE, 32'h7FFFFFFF),
           4'b1001);
      idle();
      wait_drain();
      chk("sticky_after_add", vec_t'(ovf_sticky), vec_t'(1));

      // ADD saturate
      send(ADD, 1'b1, 4'hF,
           v4(32'h7FFFFFFF, 32'd5, 32'hFFFFFFFF, 32'h80000000),
           v4(32'd1, 32'd7, 32'hFFFFFFFF, 32'hFFFFFFFF), '0,
           v4(32'h7FFFFFFF, 32'd12, 32'hFFFFFFFE, 32'h80000000),
           4'b1001);
      // MUL saturate
      send(MUL, 1'b1, 4'hF,
           v4(32'h10000, 32'd3, 32'h80000000, 32'h40000000),
           v4(32'h10000, 32'hFFFFFFFC, 32'hFFFFFFFF, 32'hFFFFFFFE), '0,
           v4(32'h7FFFFFFF, 32'hFFFFFFF4, 32'h7FFFFFFF, 32'h80000000),
           4'b0101);
      // FMA wrap, no intermediate truncation
      send(FMA, 1'b0, 4'hF,
           v4(32'h10000, 32'd3, 32'h10000, 32'h7FFFFFFF),
           v4(32'h10000, 32'hFFFFFFFC, 32'h8000, 32'h7FFFFFFF),
           v4(32'h80000000, 32'd2, 32'hFFFFFFFF, 32'd0),
           v4(32'h80000000, 32'hFFFFFFF6, 32'h7FFFFFFF, 32'd1),
           4'b1001);
      // MAX
      send(MAX, 1'b1, 4'hF,
           v4(32'hFFFFFFFB, 32'h80000000, 32'hFFFFFFFF, 32'd10),
           v4(32'd3, 32'h7FFFFFFF, 32'hFFFFFFFE, 32'd10), '0,
           v4(32'd3, 32'h7FFFFFFF, 32'hFFFFFFFF, 32'd10),
           4'b0000);
      // RELU
      send(RELU, 1'b0, 4'hF,
           v4(32'hFFFFFFF9, 32'd5, 32'h80000000, 32'h7FFFFFFF),
           '0, '0,
           v4(32'd0, 32'd5, 32'd0, 32'h7FFFFFFF),
           4'b0000);
      // Masked lanes with overflowing operands
      send(ADD, 1'b0, 4'b0101,
           v4(32'h7FFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFF),
           v4(32'd1, 32'd1, 32'd1, 32'd1), '0,
           v4(32'h80000000, 32'd0, 32'h80000000, 32'd0),
           4'b0101);
      // Undefined opcode flows through as zeros
      send(alu_opcode_e'(3'd7), 1'b0, 4'hF,
           v4(32'h7FFFFFFF, 32'd9, 32'd9, 32'd9),
           v4(32'h7FFFFFFF, 32'd9, 32'd9, 32'd9), '0,
           '0, 4'b0000);
      idle();
      wait_drain();

      // Backpressure: out_ready pattern 1,0,0 repeating
      fork
         begin
            for (int k = 0; k < 8; k++)
               send(ADD, 1'b0, 4'hF,
                    v4(k*16, k*16+1, k*16+2, k*16+3),
                    v4(k, k, k, k), '0,
                    v4(k*17, k*17+1, k*17+2, k*17+3),
                    4'b0000);
            idle();
         end
         begin
            for (int k = 0; k < 30; k++) begin
               @(negedge clk);
               out_ready = (k % 3 == 0);
            end
            out_ready = 1'b1;
         end
      join
      wait_drain();

      // Latency and throughput
      lat_chk = 1'b1;
      for (int k = 0; k < 6; k++) begin
         send(RELU, 1'b0, 4'hF, v4(k, k+1, k+2, k+3), '0, '0,
              v4(k, k+1, k+2, k+3), 4'b0000);
         if (k == 0) first_acc = last_acc;
      end
      idle();
      wait_drain();
      lat_chk = 1'b0;
      chk("throughput", vec_t'(last_acc - first_acc), vec_t'(5));

      // Reset with two beats in flight
      @(negedge clk);
      out_ready = 1'b0;
      send(ADD, 1'b0, 4'hF, v4(1, 2, 3, 4), v4(1, 1, 1, 1), '0,
           v4(2, 3, 4, 5), 4'b0000);
      send(ADD, 1'b0, 4'hF, v4(5, 6, 7, 8), v4(1, 1, 1, 1), '0,
           v4(6, 7, 8, 9), 4'b0000);
      idle();
      @(negedge clk);
      rst = 1'b1;
      q.delete();
      @(negedge clk);
      rst = 1'b0;
      #4;
      chk("rst_flight_valid", vec_t'(out_valid), vec_t'(0));
      chk("rst_flight_ready", vec_t'(in_ready), vec_t'(1));
      out_ready = 1'b1;
      repeat (6) @(posedge clk);

      // Clear coincident with overflowing handoff: set wins
      @(negedge clk);
      out_ready = 1'b0;
      send(ADD, 1'b0, 4'hF,
           v4(32'h7FFFFFFF, 32'd5, 32'hFFFFFFFF, 32'h80000000),
           v4(32'd1, 32'd7, 32'hFFFFFFFF, 32'hFFFFFFFF), '0,
           v4(32'h80000000, 32'd12, 32'hFFFFFFFE, 32'h7FFFFFFF),
           4'b1001);
      idle();
      repeat (2) @(posedge clk);
      @(negedge clk);
      out_ready = 1'b1;
      ovf_clr   = 1'b1;
      @(negedge clk);
      ovf_clr = 1'b0;
      #4;
      chk("sticky_set_wins", vec_t'(ovf_sticky), vec_t'(1));
      @(negedge clk);
      ovf_clr = 1'b1;
      @(negedge clk);
      ovf_clr = 1'b0;
      #4;
      chk("sticky_clear", vec_t'(ovf_sticky), vec_t'(0));
      chk("queue_empty", vec_t'(q.size()), vec_t'(0));

      repeat (2) @(posedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/simd_alu_pipe.md
# simd_alu_pipe

Pipelined multi-lane integer ALU; successor to the single-lane combinational ALU. Applies one `alu_opcode_e` operation across `NUM_LANES` signed lanes per beat behind a two-stage valid/ready pipeline. Adds per-lane enable masking, a selectable saturation mode and a sticky overflow status. Sits between the warp register-read stage and writeback, one instance per warp execution slot.

## Interface
- `DATA_WIDTH`, `warp_pkg::DATA_WIDTH` (32): lane width in bits, signed two's complement.
- `NUM_LANES`, 4: lanes per beat, ≥1.
- `clk` in 1: clock, all state on rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `in_valid` in 1: input beat valid.
- `in_ready` out 1: block accepts a beat this cycle.
- `in_opcode` in `alu_opcode_e`: operation for all lanes of the beat.
- `in_sat` in 1: 1 = saturate on overflow, 0 = wrap.
- `in_mask` in `NUM_LANES`: per-lane enable.
- `in_op1`, `in_op2`, `in_op3` in `NUM_LANES*DATA_WIDTH`: operands; lane i at bits [i*DATA_WIDTH +: DATA_WIDTH].
- `out_valid` out 1: result beat valid.
- `out_ready` in 1: downstream accepts.
- `out_result` out `NUM_LANES*DATA_WIDTH`: per-lane result.
- `out_ovf` out `NUM_LANES`: per-lane overflow for this beat.
- `ovf_sticky` out 1: OR of every `out_ovf` bit handed off since the last clear.
- `ovf_clr` in 1: clears `ovf_sticky`.

## Operation
- Exact result per lane, computed at full precision: ADD op1+op2 (W+1 bits); MUL op1*op2 (2W bits); FMA op1*op2+op3 (2W+1 bits, no intermediate truncation); MAX signed max(op1,op2); RELU op1<0 ? 0 : op1.
- Overflow: exact result outside [-2^(W-1), 2^(W-1)-1]. Never set for MAX, RELU, masked lanes or undefined opcodes.
- Wrap mode: result = low W bits of exact result.
- Saturate mode: on overflow, result clamps to 2^(W-1)-1 if the exact result is positive, else -2^(W-1). `out_ovf` is still reported.
- Masked lane (`in_mask[i]=0`): result 0, ovf 0.
- Undefined opcode: all lanes result 0, ovf 0; the beat still flows through.
- Stage 1 registers operands, opcode, sat and mask, plus exact products (MUL/FMA).
- Stage 2 performs the add, overflow detection and clamp, and registers the outputs.
- `ovf_sticky` sets on an output handshake (`out_valid && out_ready`) with any `out_ovf` bit set. `ovf_clr` clears it. Simultaneous set and clear: set wins.

## Timing
- Latency: a beat accepted in cycle N is presented with `out_valid=1` in cycle N+2 when not stalled.
- Throughput: one beat per cycle when `out_ready=1`.
- Handshake transfer occurs on `valid && ready`. Once `out_valid` rises, `out_result` and `out_ovf` hold stable until the handshake.
- Stage advance rules: s2 advances when `!s2_valid || out_ready`. s1 advances when `!s1_valid || s2 advances`.
- `in_ready` = s1 advance condition. This is a combinational path from `out_ready`, which is accepted.
- Full pipeline with `out_ready=0`: `in_ready=0`, contents held, no beat lost or duplicated.
- Drain: each cycle with `in_valid=0`, a bubble enters. `out_valid` falls after the last beat is accepted downstream.
- Reset values: `out_valid=0`, `out_result=0`, `out_ovf=0`, `ovf_sticky=0`, both stage valids 0. `in_ready=1` in the first cycle after reset.
- Reset mid-operation discards all in-flight beats. No output handshake occurs in the reset cycle.

## Structure
- Stays in `warp_pkg`: `alu_opcode_e` (ADD, MUL, FMA, MAX, RELU) and `DATA_WIDTH`.
- Added to `warp_pkg`: `NUM_LANES` default, and `sat_max`/`sat_min` helper constants derived from `DATA_WIDTH`.
- Sub-module `simd_alu_lane`: combinational per-lane stage-2 logic (exact result, ovf, clamp, mask), instantiated `NUM_LANES` times in a generate loop.
- The top level owns the pipeline registers, handshake and sticky flag.

## Test plan
All cases use W=32, L=4.
- **ADD wrap/sat:** lane0 ADD 0x7FFFFFFF+1, sat=0.
  - Response: 0x80000000, ovf=1.
  - Same beat with sat=1: 0x7FFFFFFF, ovf=1, `ovf_sticky`=1 after handoff.
- **MUL/FMA:**
  - MUL 0x10000×0x10000, sat=1 → 0x7FFFFFFF, ovf=1.
  - FMA 0x10000×0x10000 + (-0x7FFFFFFF-1), sat=0 → 0x80000000.
  - Then FMA 3×-4+2 → -10 (0xFFFFFFF6), ovf=0.
- **Mask/MAX/RELU:**
  - MAX -5 vs 3 → 3.
  - RELU -7 → 0.
  - mask=4'b0101 → lanes 1,3 result 0, ovf 0 even for overflowing operands.
- **Backpressure:** stream 8 beats with `out_ready` toggling 1,0,0,1,…
  - All 8 results in order, none dropped or duplicated.
  - Outputs stable while stalled.
  - `in_ready=0` whenever both stages are full and `out_ready=0`.
- **Latency/throughput:** continuous `in_valid`, `out_ready=1` → first `out_valid` 2 cycles after first accept, then one result per cycle.
- **Reset/sticky:**
  - Assert `rst` with 2 beats in flight → `out_valid=0` next cycle and those beats never appear.
  - `ovf_clr` coincident with an overflowing handoff → `ovf_sticky` stays 1.
